// File: rtl/wb_pkg.sv
// Writeback arbiter shared types.
// wb_src_e : origin of the write held in the output register (used for tracing)
// wb_req_t : buffered writeback request {rd, data}
package wb_pkg;

  // Default payload widths; wb_arbiter's ADDR_WIDTH/DATA_WIDTH default to these.
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 64;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// LSU/MUL result FIFO with parallel destination-match lookups.
// Ports: clk, rst_n (sync, active-low), push/push_req, pop/head,
//        full, empty, count, q_idx[3] -> q_match[3] (any valid entry with that rd).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  wb_req_t                         push_req,
  input  logic                            pop,
  output wb_req_t                         head,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count,
  input  logic [2:0][WB_ADDR_W-1:0]       q_idx,
  output logic [2:0]                      q_match
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage, per-entry valid bits, wrapping pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_req;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Destination match against every valid entry, one result per lookup index.
  always_comb begin
    q_match = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (vld[i] && (mem[i].rd == q_idx[k])) begin
          q_match[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (priority) and buffered LSU/MUL
// results onto the single register-file write port, with RAW/WAW lookups
// and bounded LSU starvation.
// Ports: clk, rst_n (sync, active-low)
//        alu_valid/alu_rd/alu_data -> alu_stall_c-style combinational alu_stall
//        lsu_valid/lsu_rd/lsu_data -> lsu_ready (from registered state + rst_n)
//        rf_wen/rf_rd/rf_data      : registered write port
//        q_rs1/q_rs2 -> q_busy1/q_busy2 (combinational), fifo_count
// Optional: define WB_TRACE_EN for simulation write/starvation tracing.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH = WB_DATA_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [ADDR_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  output logic                    alu_stall,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_rd,
  input  logic [DATA_WIDTH-1:0]   lsu_data,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_rd,
  output logic [DATA_WIDTH-1:0]   rf_data,
  input  logic [ADDR_WIDTH-1:0]   q_rs1,
  input  logic [ADDR_WIDTH-1:0]   q_rs2,
  output logic                    q_busy1,
  output logic                    q_busy2,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  wb_req_t                    push_req;
  wb_req_t                    head;
  logic [2:0][WB_ADDR_W-1:0]  q_idx;
  logic [2:0]                 fifo_match;
  logic [2:0]                 busy;
  logic [ST_W-1:0]            starve_cnt;
  logic                       starved;
  logic                       alu_write;

  assign lsu_ready = rst_n && !fifo_full;
  // x0 results are acknowledged but never stored.
  assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign push_req  = '{rd: WB_ADDR_W'(lsu_rd), data: WB_DATA_W'(lsu_data)};

  // Lookup slots: 0 = q_rs1, 1 = q_rs2, 2 = alu_rd (WAW check).
  assign q_idx = {WB_ADDR_W'(alu_rd), WB_ADDR_W'(q_rs2), WB_ADDR_W'(q_rs1)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .q_idx    (q_idx),
    .q_match  (fifo_match)
  );

  // Pending write: buffered in the FIFO or sitting in the output register.
  always_comb begin
    busy = '0;
    for (int k = 0; k < 3; k++) begin
      busy[k] = (q_idx[k] != '0) &&
                (fifo_match[k] || (rf_wen && (WB_ADDR_W'(rf_rd) == q_idx[k])));
    end
  end

  assign q_busy1   = busy[0];
  assign q_busy2   = busy[1];
  assign starved   = (starve_cnt == ST_W'(STARVE_MAX));
  assign alu_stall = alu_valid && (busy[2] || starved);

  // An accepted ALU write to x0 is dropped and leaves the port to the FIFO.
  assign alu_write = alu_valid && !alu_stall && (alu_rd != '0);
  assign pop       = !alu_write && !fifo_empty;

  // Output register and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      starve_cnt <= '0;
    end else begin
      rf_wen <= alu_write || pop;
      if (alu_write) begin
        rf_rd   <= alu_rd;
        rf_data <= alu_data;
      end else if (pop) begin
        rf_rd   <= ADDR_WIDTH'(head.rd);
        rf_data <= DATA_WIDTH'(head.data);
      end
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`ifdef WB_TRACE_EN
  wb_src_e     rf_src;
  int unsigned starve_stalls;

  // Simulation trace of committed writes and starvation-forced stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_src        <= WB_SRC_ALU;
      starve_stalls <= 0;
    end else begin
      if (alu_write) begin
        rf_src <= WB_SRC_ALU;
      end else if (pop) begin
        rf_src <= WB_SRC_LSU;
      end
      if (rf_wen) begin
        $display("wb x%0d <= 0x%h (%s)", rf_rd, rf_data,
                 (rf_src == WB_SRC_ALU) ? "alu" : "lsu");
      end
      if (alu_valid && starved) begin
        starve_stalls <= starve_stalls + 1;
        $display("wb starvation stall total=%0d", starve_stalls + 1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: vector table plus hand-written
// starvation and WAW sequences. Inputs change on the falling edge; outputs
// are sampled 1 time unit later, i.e. the state before the next rising edge.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_busy1;
  logic        q_busy2;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (64),
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_busy1    (q_busy1),
    .q_busy2    (q_busy2),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ldata;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_stall;
    logic        e_ready;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        e_busy1;
    logic        e_busy2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    q_rs1 = '0; q_rs2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // chk rst av ard adata lv lrd ldata q1 q2 | stall ready wen rd data b1 b2 cnt
    // Reset held two cycles with an LSU offer present.
    tv.push_back(vec_t'{0,0, 0,0,0,       1,3,'h33,   0,0,  0,0,0,0,0,      0,0,0});
    tv.push_back(vec_t'{1,0, 0,0,0,       1,3,'h33,   0,0,  0,0,0,0,0,      0,0,0});
    // ALU priority over buffered x6.
    tv.push_back(vec_t'{1,1, 0,0,0,       1,6,'h22,   6,0,  0,1,0,0,0,      0,0,0});
    tv.push_back(vec_t'{1,1, 1,5,'h11,    0,0,0,      6,5,  0,1,0,0,0,      1,0,1});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      6,5,  0,1,1,5,'h11,   1,1,1});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      6,5,  0,1,1,6,'h22,   1,0,0});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      6,5,  0,1,0,0,0,      0,0,0});
    // Backpressure: fill with ALU busy every cycle, 5th offer held.
    tv.push_back(vec_t'{1,1, 1,1,'hA1,    1,10,'h100, 10,0, 0,1,0,0,0,      0,0,0});
    tv.push_back(vec_t'{1,1, 1,2,'hA2,    1,11,'h101, 10,0, 0,1,1,1,'hA1,   1,0,1});
    tv.push_back(vec_t'{1,1, 1,1,'hA3,    1,12,'h102, 10,11,0,1,1,2,'hA2,   1,1,2});
    tv.push_back(vec_t'{1,1, 1,2,'hA4,    1,13,'h103, 10,13,0,1,1,1,'hA3,   1,0,3});
    tv.push_back(vec_t'{1,1, 1,1,'hA5,    1,14,'h104, 13,14,0,0,1,2,'hA4,   1,0,4});
    tv.push_back(vec_t'{1,1, 1,2,'hA6,    1,14,'h104, 13,14,0,0,1,1,'hA5,   1,0,4});
    tv.push_back(vec_t'{1,1, 0,0,0,       1,14,'h104, 14,10,0,0,1,2,'hA6,   0,1,4});
    tv.push_back(vec_t'{1,1, 0,0,0,       1,14,'h104, 14,10,0,1,1,10,'h100, 0,1,3});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      14,0, 0,1,1,11,'h101, 1,0,3});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      14,0, 0,1,1,12,'h102, 1,0,2});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      14,0, 0,1,1,13,'h103, 1,0,1});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      14,0, 0,1,1,14,'h104, 1,0,0});
    // x0 on both sources: nothing stored, nothing written.
    tv.push_back(vec_t'{1,1, 1,0,'h66,    1,0,'h55,   0,14, 0,1,0,0,0,      0,0,0});
    tv.push_back(vec_t'{1,1, 0,0,0,       1,9,'h99,   0,0,  0,1,0,0,0,      0,0,0});
    // FIFO pops in the cycle the ALU writes x0.
    tv.push_back(vec_t'{1,1, 1,0,'h77,    0,0,0,      0,9,  0,1,0,0,0,      0,1,1});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      0,9,  0,1,1,9,'h99,   0,1,0});
    tv.push_back(vec_t'{1,1, 0,0,0,       0,0,0,      0,9,  0,1,0,0,0,      0,0,0});

    foreach (tv[i]) begin
      @(negedge clk);
      rst_n     = tv[i].rst_n;
      alu_valid = tv[i].av;
      alu_rd    = tv[i].ard;
      alu_data  = tv[i].adata;
      lsu_valid = tv[i].lv;
      lsu_rd    = tv[i].lrd;
      lsu_data  = tv[i].ldata;
      q_rs1     = tv[i].q1;
      q_rs2     = tv[i].q2;
      #1;
      if (tv[i].chk) begin
        chk($sformatf("v%0d alu_stall", i), 64'(alu_stall), 64'(tv[i].e_stall));
        chk($sformatf("v%0d lsu_ready", i), 64'(lsu_ready), 64'(tv[i].e_ready));
        chk($sformatf("v%0d rf_wen", i), 64'(rf_wen), 64'(tv[i].e_wen));
        if (tv[i].e_wen) begin
          chk($sformatf("v%0d rf_rd", i), 64'(rf_rd), 64'(tv[i].e_rd));
          chk($sformatf("v%0d rf_data", i), rf_data, tv[i].e_data);
        end
        chk($sformatf("v%0d q_busy1", i), 64'(q_busy1), 64'(tv[i].e_busy1));
        chk($sformatf("v%0d q_busy2", i), 64'(q_busy2), 64'(tv[i].e_busy2));
        chk($sformatf("v%0d fifo_count", i), 64'(fifo_count), 64'(tv[i].e_cnt));
      end
    end

    // Starvation: x20 buffered, ALU valid every cycle on alternating x21/x22.
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'h2100;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h200;
    #1;
    chk("starve accept0", 64'(alu_stall), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      lsu_valid = 1'b0;
      alu_rd    = (k % 2 == 0) ? 5'd22 : 5'd21;
      alu_data  = 64'(k);
      #1;
      chk($sformatf("starve lost%0d stall", k), 64'(alu_stall), 64'd0);
      chk($sformatf("starve lost%0d count", k), 64'(fifo_count), 64'd1);
    end
    @(negedge clk);
    alu_rd = 5'd22; alu_data = 64'h2200;
    #1;
    chk("starve forced stall", 64'(alu_stall), 64'd1);
    @(negedge clk);
    #1;
    chk("starve head wen", 64'(rf_wen), 64'd1);
    chk("starve head rd", 64'(rf_rd), 64'd20);
    chk("starve head data", rf_data, 64'h200);
    chk("starve released", 64'(alu_stall), 64'd0);
    chk("starve count", 64'(fifo_count), 64'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    chk("starve alu after rd", 64'(rf_rd), 64'd22);
    chk("starve alu after data", rf_data, 64'h2200);

    // WAW: ALU x7 waits for the buffered x7 to leave the output register.
    @(negedge clk);
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h777;
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7A; q_rs1 = 5'd7;
    #1;
    chk("waw fifo stall", 64'(alu_stall), 64'd1);
    chk("waw fifo busy1", 64'(q_busy1), 64'd1);
    @(negedge clk);
    #1;
    chk("waw rf wen", 64'(rf_wen), 64'd1);
    chk("waw rf rd", 64'(rf_rd), 64'd7);
    chk("waw rf data", rf_data, 64'h777);
    chk("waw rf stall", 64'(alu_stall), 64'd1);
    @(negedge clk);
    #1;
    chk("waw cleared stall", 64'(alu_stall), 64'd0);
    chk("waw cleared wen", 64'(rf_wen), 64'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    chk("waw alu wen", 64'(rf_wen), 64'd1);
    chk("waw alu rd", 64'(rf_rd), 64'd7);
    chk("waw alu data", rf_data, 64'h7A);

    // Reset mid-operation discards buffered results.
    @(negedge clk);
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'h3;
    @(negedge clk);
    lsu_rd = 5'd4;
    @(negedge clk);
    lsu_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset count", 64'(fifo_count), 64'd0);
    chk("midreset wen", 64'(rf_wen), 64'd0);
    @(negedge clk);
    #1;
    chk("midreset no write", 64'(rf_wen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Writeback arbiter between the execute stage and the register file's single write port.
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results, which have priority;
  - multi-cycle LSU/MUL results, buffered in a small FIFO.
- Provides pending-write lookups so decode can stall on RAW hazards.
- Enforces WAW ordering and bounds LSU starvation.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, register data width
- DEPTH, 4, LSU FIFO entries; power of two, ≥2
- STARVE_MAX, 8, consecutive cycles the FIFO head may lose arbitration before the ALU is stalled

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- alu_stall  out  1  ALU result not accepted; upstream holds it
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept
- lsu_rd  in  ADDR_WIDTH  LSU destination
- lsu_data  in  DATA_WIDTH  LSU result
- rf_wen  out  1  register file write enable
- rf_rd  out  ADDR_WIDTH  write index
- rf_data  out  DATA_WIDTH  write data
- q_rs1, q_rs2  in  ADDR_WIDTH  decode lookup indices
- q_busy1, q_busy2  out  1  pending write exists to that index
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **LSU enqueue.** Occurs when lsu_valid && lsu_ready, where lsu_ready = !full && rst_n.
  - lsu_rd==0 is accepted but not stored.
- **Busy match.** Index r is busy iff r!=0 and it matches either:
  - any valid FIFO entry; or
  - rf_rd while rf_wen=1.
- **q_busy1/q_busy2.** Busy match of q_rs1/q_rs2; combinational.
- **alu_stall.** Combinational; asserted when alu_valid and either:
  - busy match of alu_rd (WAW protection); or
  - starve counter == STARVE_MAX.
- **Arbitration** (per cycle, priority order):
  1. ALU accepted (alu_valid && !alu_stall) with alu_rd!=0 → output register loads ALU write.
  2. Otherwise, FIFO non-empty → pop head into output register.
  3. Otherwise → rf_wen=0 next cycle.
- **ALU writes to x0** are accepted and dropped. They do not occupy the port, so the FIFO may pop that cycle.
- **Starve counter:**
  - increments when the FIFO is non-empty and not popped;
  - clears on pop or when empty;
  - saturates at STARVE_MAX.
- **Simultaneous push and pop.** Legal in the same cycle; count unchanged.
- **Pointers** wrap modulo DEPTH; full when count==DEPTH.

## Timing
- **Latency.** Accepted write → rf_wen/rf_rd/rf_data one cycle later (registered). The register file commits on the following edge.
- **Reset** (rst_n low at posedge):
  - rf_wen=0, rf_rd=0, rf_data=0;
  - FIFO emptied, fifo_count=0, starve counter=0.
- **During reset:** lsu_ready=0; alu_stall follows its equation on the reset-cleared state.
- **Reset mid-operation** discards all buffered LSU results with no write issued.
- **lsu_ready** depends only on registered state; no combinational path from lsu_valid.
- **Enqueue/lookup timing.** An entry enqueued at edge N is visible to q_busy* from cycle N+1.

## Configuration
- **WB_TRACE_EN defined:**
  - each rf_wen cycle prints `wb x<rd> <= 0x<data> (alu|lsu)`;
  - a stall-cycle counter prints its total on each starvation-forced stall.
  - Simulation-only; no effect on outputs.
- **WB_TRACE_EN undefined:** no display statements or trace state are compiled.

## Structure
- **Package wb_pkg:**
  - wb_src_e enum (WB_SRC_ALU, WB_SRC_LSU), carried in the output register for tracing;
  - wb_req_t struct {rd, data}.
- **Sub-module wb_fifo:**
  - storage, pointers, count;
  - three parallel index-match outputs for q_rs1, q_rs2 and alu_rd.
- **Top level:** arbitration, starve counter, output register, rf_wen/rf_rd busy term.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with lsu_valid=1 → lsu_ready=0, rf_wen=0, fifo_count=0; after release, lsu_ready=1.
- **ALU priority:** alu writes x5=0x11 while the FIFO holds x6=0x22 → rf x5=0x11 at cycle 1, x6=0x22 at cycle 2.
- **Backpressure:** push 4 LSU results with alu_valid=1 continuously (rd≠pending) → lsu_ready=0 at fifo_count=4; a 5th offer is held, not lost.
- **Starvation:** FIFO non-empty with ALU valid every cycle → after 8 lost cycles, alu_stall=1 for one cycle and the FIFO head is written.
- **WAW:** FIFO holds x7; alu_rd=7 → alu_stall=1 until x7 reaches rf_wen and clears; then the ALU x7 write follows.
- **x0:**
  - lsu_rd=0 and alu_rd=0 → never rf_wen;
  - q_rs1=0 → q_busy1=0 always;
  - the FIFO pops in the ALU-x0 cycle.
